// File: rtl/commit_trace_tx_if.sv
// rtl/commit_trace_tx_if.sv - commit capture and byte-stream signals between core, tracer and host link
interface commit_trace_tx_if #(
    parameter int DROP_W = 8
);
    logic              trace_en;
    logic              commit_valid;
    logic [31:0]       commit_pc;
    logic [31:0]       commit_instr;
    logic              commit_we;
    logic [4:0]        commit_rd;
    logic [31:0]       commit_wdata;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic [DROP_W-1:0] drop_cnt;
    logic              busy;

    modport master (
        output trace_en, commit_valid, commit_pc, commit_instr, commit_we, commit_rd,
               commit_wdata, tx_ready,
        input  tx_data, tx_valid, drop_cnt, busy
    );

    modport slave (
        input  trace_en, commit_valid, commit_pc, commit_instr, commit_we, commit_rd,
               commit_wdata, tx_ready,
        output tx_data, tx_valid, drop_cnt, busy
    );
endinterface

// File: rtl/commit_trace_tx.sv
// rtl/commit_trace_tx.sv - buffers retired-instruction records and serialises them as 14-byte frames
module commit_trace_tx #(
    parameter int          DEPTH    = 4,
    parameter logic [7:0]  HDR_BYTE = 8'hA5,
    parameter int          DROP_W   = 8
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    commit_trace_tx_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [3:0] LAST_IDX = 4'd13;

    typedef enum logic {S_IDLE, S_SEND} state_t;

    // Stored record excludes the constant header: {pc, instr, flags, wdata}
    logic [103:0]      mem_q [DEPTH];
    logic [AW:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    state_t            state_q, state_d;
    logic [3:0]        idx_q, idx_d;
    logic [DROP_W-1:0] drop_q, drop_d;
    logic              lost_q, lost_d;

    logic          empty, full, commit, hs, pop_now, push, drop;
    logic [103:0]  new_rec;
    logic [111:0]  frame_sh;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign commit  = bus.commit_valid & bus.trace_en;
    assign hs      = (state_q == S_SEND) & bus.tx_ready;
    assign pop_now = hs & (idx_q == LAST_IDX);
    assign push    = commit & (!full | pop_now);
    assign drop    = commit & full & !pop_now;

    assign new_rec = {bus.commit_pc, bus.commit_instr,
                      bus.commit_we, lost_q, 1'b0, bus.commit_rd,
                      bus.commit_we ? bus.commit_wdata : 32'h0};

    // A push into a full FIFO only happens alongside the head's final byte,
    // so overwriting the head slot on that edge is safe.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= new_rec;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q + (AW+1)'(push);
        rd_ptr_d = rd_ptr_q + (AW+1)'(pop_now);
        drop_d   = drop_q;
        lost_d   = lost_q;
        state_d  = state_q;
        idx_d    = idx_q;

        if (drop && (drop_q != {DROP_W{1'b1}})) begin
            drop_d = drop_q + DROP_W'(1);
        end
        if (push) begin
            lost_d = 1'b0;
        end else if (drop) begin
            lost_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    state_d = S_SEND;
                    idx_d   = 4'd0;
                end
            end
            S_SEND: begin
                if (hs) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d   = 4'd0;
                        state_d = (wr_ptr_d != rd_ptr_d) ? S_SEND : S_IDLE;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            state_q  <= S_IDLE;
            idx_q    <= 4'd0;
            drop_q   <= '0;
            lost_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            state_q  <= state_d;
            idx_q    <= idx_d;
            drop_q   <= drop_d;
            lost_q   <= lost_d;
        end
    end

    // Head slot and index are frozen during a stall, so the byte holds without a register.
    assign frame_sh     = {HDR_BYTE, mem_q[rd_ptr_q[AW-1:0]]} << {idx_q, 3'b000};
    assign bus.tx_data  = (state_q == S_SEND) ? frame_sh[111:104] : 8'h00;
    assign bus.tx_valid = (state_q == S_SEND);
    assign bus.drop_cnt = drop_q;
    assign bus.busy     = !empty | (state_q == S_SEND);
endmodule

// File: tb/tb_commit_trace_tx.sv
// tb/tb_commit_trace_tx.sv - randomized and directed checks of commit_trace_tx against a record-queue model
module tb_commit_trace_tx;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    commit_trace_tx_if #(.DROP_W(8)) bus ();

    commit_trace_tx #(.DEPTH(DEPTH), .HDR_BYTE(8'hA5), .DROP_W(8)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    int checks = 0;
    int failures = 0;

    logic [111:0] mq [$];
    logic [7:0]   cap [$];
    bit           m_send = 0;
    int           m_idx = 0;
    int           m_drop = 0;
    bit           m_lost = 0;

    logic [7:0] exp1 [14] = '{8'hA5, 8'h00, 8'h40, 8'h00, 8'h00, 8'h01, 8'h2A,
                              8'h40, 8'h20, 8'h88, 8'h00, 8'h00, 8'h00, 8'h0F};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [111:0] mk_rec(input logic [31:0] pc, input logic [31:0] instr,
                                            input logic we, input logic lost,
                                            input logic [4:0] rd, input logic [31:0] wdata);
        return {8'hA5, pc, instr, we, lost, 1'b0, rd, (we ? wdata : 32'h0)};
    endfunction

    // Advance the model by one clock edge using the currently driven inputs, then compare.
    task automatic tick();
        bit hs, pop, full;
        int pre;
        logic [111:0] head;
        hs   = m_send && bus.tx_ready;
        if (hs) cap.push_back(bus.tx_data);
        pre  = mq.size();
        full = (pre == DEPTH);
        pop  = hs && (m_idx == 13);
        if (bus.commit_valid && bus.trace_en) begin
            if (!full || pop) begin
                mq.push_back(mk_rec(bus.commit_pc, bus.commit_instr, bus.commit_we, m_lost,
                                    bus.commit_rd, bus.commit_wdata));
                m_lost = 0;
            end else begin
                if (m_drop < 255) m_drop++;
                m_lost = 1;
            end
        end
        if (hs) begin
            if (pop) begin
                void'(mq.pop_front());
                m_idx  = 0;
                m_send = (mq.size() > 0);
            end else begin
                m_idx++;
            end
        end else if (!m_send && pre > 0) begin
            m_send = 1;
            m_idx  = 0;
        end
        @(posedge clk);
        @(negedge clk);
        check("tx_valid", 32'(bus.tx_valid), 32'(m_send));
        if (m_send) begin
            head = mq[0];
            check("tx_data", 32'(bus.tx_data), 32'(head[111 - 8*m_idx -: 8]));
        end
        check("drop_cnt", 32'(bus.drop_cnt), 32'(m_drop));
        check("busy", 32'(bus.busy), 32'(mq.size() > 0 || m_send));
    endtask

    task automatic set_commit(input bit v, input logic [31:0] pc, input logic [31:0] instr,
                              input logic we, input logic [4:0] rd, input logic [31:0] wdata);
        bus.commit_valid = v;
        bus.commit_pc    = pc;
        bus.commit_instr = instr;
        bus.commit_we    = we;
        bus.commit_rd    = rd;
        bus.commit_wdata = wdata;
    endtask

    task automatic rand_commit(input bit v);
        set_commit(v, $urandom, $urandom, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.trace_en = 1'b0;
        bus.tx_ready = 1'b0;
        set_commit(0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        check("rst_valid", 32'(bus.tx_valid), 32'd0);
        check("rst_data", 32'(bus.tx_data), 32'd0);
        check("rst_drop", 32'(bus.drop_cnt), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        rst_n = 1'b1;

        // single record, ready held high
        bus.trace_en = 1'b1;
        bus.tx_ready = 1'b1;
        set_commit(1, 32'h0040_0000, 32'h012A_4020, 1'b1, 5'd8, 32'h0000_000F);
        tick();
        bus.commit_valid = 1'b0;
        repeat (17) tick();
        check("t1_len", 32'(cap.size()), 32'd14);
        for (int i = 0; i < 14 && i < cap.size(); i++) check("t1_byte", 32'(cap[i]), 32'(exp1[i]));

        // same record under 1,0,0 back-pressure
        cap.delete();
        set_commit(1, 32'h0040_0000, 32'h012A_4020, 1'b1, 5'd8, 32'h0000_000F);
        tick();
        bus.commit_valid = 1'b0;
        for (int i = 0; i < 50; i++) begin
            bus.tx_ready = (i % 3 == 0);
            tick();
        end
        check("t2_len", 32'(cap.size()), 32'd14);
        for (int i = 0; i < 14 && i < cap.size(); i++) check("t2_byte", 32'(cap[i]), 32'(exp1[i]));

        // NOP with we=0
        cap.delete();
        bus.tx_ready = 1'b1;
        set_commit(1, 32'h0000_1000, 32'h0, 1'b0, 5'd3, 32'hDEAD_BEEF);
        tick();
        bus.commit_valid = 1'b0;
        repeat (16) tick();
        check("t5_len", 32'(cap.size()), 32'd14);
        if (cap.size() == 14) begin
            check("t5_flags", 32'(cap[9]), 32'h03);
            check("t5_wdata", {cap[10], cap[11], cap[12], cap[13]}, 32'h0);
        end

        // overflow: 6 commits with sink stalled
        cap.delete();
        bus.tx_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            rand_commit(1);
            tick();
        end
        bus.commit_valid = 1'b0;
        check("t3_drop", 32'(bus.drop_cnt), 32'd2);
        bus.tx_ready = 1'b1;
        repeat (60) tick();
        for (int i = 0; i < 2; i++) begin
            rand_commit(1);
            tick();
            bus.commit_valid = 1'b0;
            repeat (16) tick();
        end
        check("t3_len", 32'(cap.size()), 32'd84);
        if (cap.size() == 84) begin
            check("t3_lost_set", 32'(cap[4*14+9][6]), 32'd1);
            check("t3_lost_clr", 32'(cap[5*14+9][6]), 32'd0);
        end

        // randomized traffic with varying commit and ready densities
        for (int ph = 0; ph < 6; ph++) begin
            int pr, pc;
            pr = (ph % 3 == 0) ? 100 : ((ph % 3 == 1) ? 70 : 30);
            pc = (ph < 3) ? 15 : 60;
            for (int i = 0; i < 500; i++) begin
                bus.tx_ready = ($urandom_range(0, 99) < pr);
                bus.trace_en = ($urandom_range(0, 99) < 90);
                rand_commit($urandom_range(0, 99) < pc);
                tick();
            end
        end

        // reset at byte 7 of a record with two more queued
        bus.trace_en = 1'b1;
        bus.tx_ready = 1'b1;
        for (int i = 0; i < 200 && (m_send || mq.size() > 0); i++) begin
            bus.commit_valid = 1'b0;
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            rand_commit(1);
            tick();
        end
        bus.commit_valid = 1'b0;
        for (int i = 0; i < 30 && !(m_send && m_idx == 7); i++) tick();
        check("t6_at_byte7", 32'(m_send && m_idx == 7 && mq.size() == 3), 32'd1);
        rst_n = 1'b0;
        #1;
        check("t6_valid", 32'(bus.tx_valid), 32'd0);
        check("t6_busy", 32'(bus.busy), 32'd0);
        check("t6_drop", 32'(bus.drop_cnt), 32'd0);
        mq.delete();
        m_send = 0;
        m_idx  = 0;
        m_drop = 0;
        m_lost = 0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
